// File: rtl/wb_buffer.sv
// Write-back buffer: a small FIFO of pending register writes that drains one entry per
// cycle into the register file and forwards the youngest pending value for each read select.
module wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               in_reg,
  input  logic [15:0]              in_data,
  output logic                     in_ready,
  input  logic                     drain_en,
  output logic [2:0]               writeregsel,
  output logic [15:0]              writedata,
  output logic                     write,
  input  logic [2:0]               lk1_sel,
  input  logic [2:0]               lk2_sel,
  output logic                     lk1_hit,
  output logic                     lk2_hit,
  output logic [15:0]              lk1_data,
  output logic [15:0]              lk2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]    reg_mem_q  [DEPTH];
  logic [15:0]   data_mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          enq, deq;

  // Full flag comes from registered occupancy only, so drain_en never reaches in_ready.
  assign in_ready    = (count_q != CW'(DEPTH));
  assign enq         = in_valid & in_ready;
  assign deq         = (count_q != '0) & drain_en;
  assign write       = deq;
  assign writeregsel = reg_mem_q[head_q];
  assign writedata   = data_mem_q[head_q];
  assign count       = count_q;
  assign err         = err_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = in_valid & ~in_ready;
    if (enq) tail_d = tail_q + 1'b1;
    if (deq) head_d = head_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match (closest to tail) wins; the head
  // being drained this cycle is still occupied, avoiding a forwarding gap.
  always_comb begin
    lk1_hit  = 1'b0;
    lk2_hit  = 1'b0;
    lk1_data = '0;
    lk2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (reg_mem_q[head_q + PW'(i)] == lk1_sel) begin
          lk1_hit  = 1'b1;
          lk1_data = data_mem_q[head_q + PW'(i)];
        end
        if (reg_mem_q[head_q + PW'(i)] == lk2_sel) begin
          lk2_hit  = 1'b1;
          lk2_data = data_mem_q[head_q + PW'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (enq) begin
        reg_mem_q[tail_q]  <= in_reg;
        data_mem_q[tail_q] <= in_data;
      end
    end
  end
endmodule
